// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared state/fault encodings and input vector layout for the tank fill controller
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    HOLD  = 2'b10,
    FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'b00,
    F_SENSOR  = 2'b01,
    F_TIMEOUT = 2'b10
  } fault_t;

  localparam int IN_W    = 7;
  localparam int B_VE    = 0;
  localparam int B_AL    = 1;
  localparam int B_ERRO  = 2;
  localparam int B_CRIT  = 3;
  localparam int B_BAIXO = 4;
  localparam int B_MEDIO = 5;
  localparam int B_ALTO  = 6;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/tank_in_filter.sv
// rtl/tank_in_filter.sv - 2-flop synchroniser and debounce filter for the decoder flag vector
module tank_in_filter
  import tank_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] raw_vec,
  output logic [IN_W-1:0] filt_vec,
  output logic            valid
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [IN_W-1:0]  sync1, sync2, prev;
  logic [CNT_W-1:0] cnt, cnt_next;

  // cnt_next is the number of cycles sync2 has held its current value, saturating
  always_comb begin
    cnt_next = cnt;
    if (sync2 != prev) begin
      cnt_next = CNT_W'(1);
    end else if (cnt != CNT_W'(DEB_CYCLES)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      cnt      <= '0;
      filt_vec <= '0;
      valid    <= 1'b0;
    end else begin
      sync1 <= raw_vec;
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= cnt_next;
      if (cnt_next == CNT_W'(DEB_CYCLES)) begin
        filt_vec <= sync2;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tank_fill_ctrl.sv
// rtl/tank_fill_ctrl.sv - fill-valve FSM with hysteresis, fill timeout and latched fault
// Optional blinking fault alarm enabled by defining TANK_ALARM_BLINK_EN.
module tank_fill_ctrl
  import tank_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int FILL_TIMEOUT = 1000,
  parameter int BLINK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ve_req,
  input  logic       al_req,
  input  logic       erro,
  input  logic       nv_critico,
  input  logic       nv_baixo,
  input  logic       nv_medio,
  input  logic       nv_alto,
  input  logic       fault_clr,
  output logic       valve_open,
  output logic       alarm,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] state
);

  localparam int TIMER_W = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;

  logic [IN_W-1:0]    raw_vec, filt;
  logic               valid, sensor_bad, alarm_next;
  state_t             cur, state_next;
  fault_t             code, code_next;
  logic [TIMER_W-1:0] fill_timer;

  assign raw_vec = {nv_alto, nv_medio, nv_baixo, nv_critico, erro, al_req, ve_req};

  tank_in_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_vec  (raw_vec),
    .filt_vec (filt),
    .valid    (valid)
  );

  assign sensor_bad = valid &&
      (filt[B_ERRO] || !onehot4({filt[B_ALTO], filt[B_MEDIO], filt[B_BAIXO], filt[B_CRIT]}));

  always_comb begin
    state_next = cur;
    code_next  = code;
    if (!valid) begin
      state_next = IDLE;
    end else if (sensor_bad) begin
      state_next = FAULT;
      if (cur != FAULT) code_next = F_SENSOR;
    end else begin
      case (cur)
        IDLE:  if (filt[B_VE]) state_next = FILL;
        // reaching the high level outranks a coincident timeout
        FILL: begin
          if (filt[B_ALTO] || !filt[B_VE]) begin
            state_next = HOLD;
          end else if (fill_timer == TIMER_W'(FILL_TIMEOUT - 1)) begin
            state_next = FAULT;
            code_next  = F_TIMEOUT;
          end
        end
        HOLD:  if (filt[B_VE] && (filt[B_BAIXO] || filt[B_CRIT])) state_next = FILL;
        FAULT: begin
          if (fault_clr) begin
            state_next = IDLE;
            code_next  = F_NONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef TANK_ALARM_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_W-1:0] blink_cnt, blink_cnt_next;
  logic               blink_on, blink_on_next;

  // blink phase restarts high on every entry into FAULT
  always_comb begin
    blink_cnt_next = '0;
    blink_on_next  = 1'b1;
    if (state_next == FAULT && cur == FAULT) begin
      if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
        blink_on_next = ~blink_on;
      end else begin
        blink_cnt_next = blink_cnt + BLINK_W'(1);
        blink_on_next  = blink_on;
      end
    end
    alarm_next = (state_next == FAULT) ? blink_on_next : filt[B_AL];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_next;
      blink_on  <= blink_on_next;
    end
  end
`else
  always_comb begin
    alarm_next = filt[B_AL] || (state_next == FAULT);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= IDLE;
      code       <= F_NONE;
      fill_timer <= '0;
      valve_open <= 1'b0;
      fault      <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      cur        <= state_next;
      code       <= code_next;
      fill_timer <= (cur == FILL && state_next == FILL) ? fill_timer + TIMER_W'(1) : '0;
      valve_open <= (state_next == FILL);
      fault      <= (state_next == FAULT);
      alarm      <= alarm_next;
    end
  end

  assign state      = cur;
  assign fault_code = code;

endmodule
